mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences the shared datapath (PC, IR, register file, immediate generator, ALU, unified memory port) through fetch/decode/execute/memory/writeback. It decodes the opcode class from the latched IR and drives every datapath enable and mux select. It also retires instructions and detects illegal opcodes and memory-port timeouts.

Parameters:
TIMEOUT_CYCLES, 255, max cycles a FETCH/MEM request may wait for mem_ready before trapping (1..65535)
CNT_W, 16, width of wait counter and of retire counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr  in  32  current IR contents (opcode = instr[6:0])
mem_ready  in  1  memory port completion, sampled while mem_req=1
branch_taken  in  1  ALU compare result, valid in EXEC
mem_req  out  1  memory request
mem_we  out  1  store strobe, qualifies mem_req
addr_sel  out  1  0=PC, 1=ALU result
ir_we  out  1  latch fetched word into IR
pc_we  out  1  PC write enable
oldpc_we  out  1  latch PC into OLDPC
pc_src  out  2  0=PC+4, 1=OLDPC+imm, 2=ALU result & ~1 (JALR)
alu_a_sel  out  2  0=rs1, 1=OLDPC, 2=zero
alu_b_sel  out  1  0=rs2, 1=imm
alu_mode  out  2  0=ADD, 1=compare (funct3), 2=funct3/funct7 op
reg_we  out  1  register file write
wb_sel  out  2  0=ALU, 1=memory data, 2=PC (already PC+4)
retire  out  1  one-cycle pulse per completed instruction
retire_cnt  out  CNT_W  retired instruction count, wraps
trap  out  1  sticky fault flag
trap_cause  out  2  0=none, 1=illegal opcode, 2=mem timeout

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Registered state, Moore outputs, except for the ready/taken-qualified strobes noted below.
- Reset (async, rst_n=0): state=FETCH; all strobes 0; retire_cnt=0; trap=0; trap_cause=0; wait counter=0. Reset mid-instruction abandons it without a partial write.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. ir_we, pc_we (pc_src=0) and oldpc_we assert only in the cycle mem_ready=1, then go to DECODE. Minimum latency is 1 cycle.
- DECODE: 1 cycle, regfile read. Valid opcodes are 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, and 0110011 OP. Any other opcode goes to TRAP with cause 1. A valid opcode goes to EXEC.
- EXEC, by class:
  - LUI: a=zero, b=imm, ADD, then WB.
  - AUIPC: a=OLDPC, b=imm, ADD, then WB.
  - OP-IMM: a=rs1, b=imm, mode 2, then WB.
  - OP: a=rs1, b=rs2, mode 2, then WB.
  - LOAD/STORE: a=rs1, b=imm, ADD, then MEM.
  - BRANCH: a=rs1, b=rs2, mode 1; pc_we=branch_taken, pc_src=1; retire=1; then FETCH.
  - JAL: pc_we=1, pc_src=1, reg_we=1, wb_sel=2; retire=1; then FETCH.
  - JALR: a=rs1, b=imm, ADD; pc_we=1, pc_src=2, reg_we=1, wb_sel=2; retire=1; then FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE. ALU inputs are held as in EXEC. On mem_ready: STORE retires and goes to FETCH; LOAD goes to WB.
- WB: reg_we=1; wb_sel=1 for LOAD, else 0; retire=1; then FETCH. Writes to rd=x0 are still strobed; the regfile discards them.
- Timeout: the wait counter clears on entry to FETCH/MEM and increments each cycle mem_ready=0. When it reaches TIMEOUT_CYCLES with mem_ready still 0, go to TRAP with cause 2. mem_ready=1 in that same cycle wins: the access completes and there is no trap.
- TRAP: all strobes 0; trap=1; trap_cause holds. Exit only by reset.
- retire_cnt increments by 1 on each retire pulse and wraps from 2^CNT_W−1 to 0.
- CPI: ALU ops 4, loads 5, stores 4, branch/jump 3, each plus memory wait cycles.

Decomposition:
- Package rv32i_pkg holds:
  - opcode localparams, shared with the immediate generator;
  - state encoding;
  - pc_src, alu_a_sel, wb_sel and alu_mode encodings;
  - trap cause codes.
- One sub-module, mc_ctrl_dec: combinational opcode→class one-hot plus illegal flag. The FSM and counters live in mc_ctrl.

Test Plan:
- Reset with rst_n low mid-MEM → state FETCH, all strobes 0, retire_cnt=0 asynchronously. Release → mem_req=1 on the next edge.
- ADDI x1,x0,5 (0x00500093), mem_ready=1 immediately → ir_we in cycle 0, reg_we with wb_sel=0 in cycle 3, retire pulse, retire_cnt=1.
- LW (0x0000A103) with mem_ready delayed 3 cycles in MEM → mem_req and addr_sel=1 held 4 cycles, mem_we=0, then WB with wb_sel=1.
- BEQ (0x00000463) with branch_taken=0 then 1 → pc_we=0 and then pc_we=1 with pc_src=1; both retire in 3 cycles.
- instr=0x0000007F → TRAP cause 1 after DECODE, trap sticky, no reg_we/pc_we afterwards. With TIMEOUT_CYCLES=4 and mem_ready held 0 in FETCH → TRAP cause 2 after exactly 4 wait cycles. mem_ready=1 on the 4th cycle → no trap.
- Preload retire_cnt path: 2^CNT_W retires → retire_cnt wraps to 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the multi-cycle core.
// Contents: major-opcode constants (also used by the immediate generator),
// control-FSM state encoding, datapath mux-select and ALU-mode encodings,
// trap cause codes and the one-hot opcode-class struct produced by the
// decoder.
package rv32i_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Control FSM states
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  // Next-PC source
  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;  // PC + 4
  localparam logic [1:0] PC_SRC_OLDIMM = 2'd1;  // OLDPC + imm
  localparam logic [1:0] PC_SRC_ALU    = 2'd2;  // ALU result & ~1

  // ALU operand A select
  localparam logic [1:0] ALU_A_RS1   = 2'd0;
  localparam logic [1:0] ALU_A_OLDPC = 2'd1;
  localparam logic [1:0] ALU_A_ZERO  = 2'd2;

  // ALU operand B select
  localparam logic ALU_B_RS2 = 1'b0;
  localparam logic ALU_B_IMM = 1'b1;

  // ALU mode
  localparam logic [1:0] ALU_MODE_ADD  = 2'd0;
  localparam logic [1:0] ALU_MODE_CMP  = 2'd1;
  localparam logic [1:0] ALU_MODE_FUNC = 2'd2;

  // Register write-back source
  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC  = 2'd2;

  // Trap causes
  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

  // One-hot opcode class
  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic op_imm;
    logic op;
  } op_class_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Opcode-class decoder for the multi-cycle control FSM.
// Purely combinational.
// Ports:
//   opcode  in   7  instr[6:0] of the latched IR
//   cls     out     one-hot opcode class (all zero when illegal)
//   illegal out  1  opcode is not one of the supported RV32I classes
module mc_ctrl_dec
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  cls,
  output logic       illegal
);

  always_comb begin
    cls = '0;
    unique case (opcode)
      OPC_LUI:    cls.lui    = 1'b1;
      OPC_AUIPC:  cls.auipc  = 1'b1;
      OPC_JAL:    cls.jal    = 1'b1;
      OPC_JALR:   cls.jalr   = 1'b1;
      OPC_BRANCH: cls.branch = 1'b1;
      OPC_LOAD:   cls.load   = 1'b1;
      OPC_STORE:  cls.store  = 1'b1;
      OPC_OP_IMM: cls.op_imm = 1'b1;
      OPC_OP:     cls.op     = 1'b1;
      default:    cls        = '0;
    endcase
  end

  assign illegal = ~|cls;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core.
// Sequences the shared datapath through FETCH/DECODE/EXEC/MEM/WB, drives all
// datapath enables and mux selects, counts retired instructions and traps on
// illegal opcodes or memory-port timeouts (TRAP is left only by reset).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   instr[31:0]          current IR contents (opcode = instr[6:0])
//   mem_ready            memory completion, meaningful while mem_req=1
//   branch_taken         ALU compare result, used in EXEC for branches
//   mem_req/mem_we/addr_sel            memory port controls
//   ir_we/pc_we/oldpc_we/pc_src        IR/PC/OLDPC controls
//   alu_a_sel/alu_b_sel/alu_mode       ALU operand and mode selects
//   reg_we/wb_sel                      register write-back controls
//   retire, retire_cnt                 retire pulse and wrapping count
//   trap, trap_cause                   sticky fault flag and cause
//   dbg_state                          current FSM state (state_e encoding)
//
// Handshake: a memory access is in flight in every cycle mem_req=1; it
// completes in the cycle mem_ready=1 is sampled at the rising edge together
// with mem_req=1. mem_ready is ignored while mem_req=0.
module mc_ctrl
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             oldpc_we,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       alu_mode,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       dbg_state
);

  // Last wait-count value before the timeout fires: a request that has
  // already waited TIMEOUT_CYCLES-1 cycles and sees mem_ready=0 again traps.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             run_q, run_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [1:0]       trap_cause_q, trap_cause_d;

  op_class_t cls;
  logic      illegal;
  logic      unused_instr_bits;

  mc_ctrl_dec u_dec (
    .opcode  (instr[6:0]),
    .cls     (cls),
    .illegal (illegal)
  );

  // Only the opcode field steers control; the rest of the IR feeds the
  // immediate generator and register file elsewhere.
  assign unused_instr_bits = ^instr[31:7];

  // run_q keeps every strobe low while reset is asserted and for the
  // reset-release edge, so the first request appears one edge after release.
  assign run_d = 1'b1;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    trap_cause_d = trap_cause_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    oldpc_we     = 1'b0;
    pc_src       = PC_SRC_PLUS4;
    alu_a_sel    = ALU_A_RS1;
    alu_b_sel    = ALU_B_RS2;
    alu_mode     = ALU_MODE_ADD;
    reg_we       = 1'b0;
    wb_sel       = WB_SEL_ALU;
    retire       = 1'b0;

    if (run_q) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          addr_sel = 1'b0;
          if (mem_ready) begin
            ir_we    = 1'b1;
            pc_we    = 1'b1;
            oldpc_we = 1'b1;
            pc_src   = PC_SRC_PLUS4;
            state_d  = S_DECODE;
          end else if (wait_q == WAIT_LAST) begin
            state_d      = S_TRAP;
            trap_cause_d = TRAP_TIMEOUT;
          end else begin
            wait_d = wait_q + CNT_W'(1);
          end
        end

        S_DECODE: begin
          if (illegal) begin
            state_d      = S_TRAP;
            trap_cause_d = TRAP_ILLEGAL;
          end else begin
            state_d = S_EXEC;
          end
        end

        S_EXEC: begin
          if (cls.lui) begin
            alu_a_sel = ALU_A_ZERO;
            alu_b_sel = ALU_B_IMM;
            alu_mode  = ALU_MODE_ADD;
            state_d   = S_WB;
          end else if (cls.auipc) begin
            alu_a_sel = ALU_A_OLDPC;
            alu_b_sel = ALU_B_IMM;
            alu_mode  = ALU_MODE_ADD;
            state_d   = S_WB;
          end else if (cls.op_imm) begin
            alu_a_sel = ALU_A_RS1;
            alu_b_sel = ALU_B_IMM;
            alu_mode  = ALU_MODE_FUNC;
            state_d   = S_WB;
          end else if (cls.op) begin
            alu_a_sel = ALU_A_RS1;
            alu_b_sel = ALU_B_RS2;
            alu_mode  = ALU_MODE_FUNC;
            state_d   = S_WB;
          end else if (cls.load || cls.store) begin
            alu_a_sel = ALU_A_RS1;
            alu_b_sel = ALU_B_IMM;
            alu_mode  = ALU_MODE_ADD;
            state_d   = S_MEM;
          end else if (cls.branch) begin
            alu_a_sel = ALU_A_RS1;
            alu_b_sel = ALU_B_RS2;
            alu_mode  = ALU_MODE_CMP;
            pc_we     = branch_taken;
            pc_src    = PC_SRC_OLDIMM;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end else if (cls.jal) begin
            pc_we   = 1'b1;
            pc_src  = PC_SRC_OLDIMM;
            reg_we  = 1'b1;
            wb_sel  = WB_SEL_PC;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else if (cls.jalr) begin
            alu_a_sel = ALU_A_RS1;
            alu_b_sel = ALU_B_IMM;
            alu_mode  = ALU_MODE_ADD;
            pc_we     = 1'b1;
            pc_src    = PC_SRC_ALU;
            reg_we    = 1'b1;
            wb_sel    = WB_SEL_PC;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end else begin
            // IR is stable after DECODE, so this only guards against a
            // corrupted IR; treat it as illegal rather than guess.
            state_d      = S_TRAP;
            trap_cause_d = TRAP_ILLEGAL;
          end
        end

        S_MEM: begin
          mem_req   = 1'b1;
          addr_sel  = 1'b1;
          mem_we    = cls.store;
          // Address must stay valid for the whole access.
          alu_a_sel = ALU_A_RS1;
          alu_b_sel = ALU_B_IMM;
          alu_mode  = ALU_MODE_ADD;
          if (mem_ready) begin
            if (cls.store) begin
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (wait_q == WAIT_LAST) begin
            state_d      = S_TRAP;
            trap_cause_d = TRAP_TIMEOUT;
          end else begin
            wait_d = wait_q + CNT_W'(1);
          end
        end

        S_WB: begin
          reg_we  = 1'b1;
          wb_sel  = cls.load ? WB_SEL_MEM : WB_SEL_ALU;
          retire  = 1'b1;
          state_d = S_FETCH;
        end

        S_TRAP: begin
          state_d = S_TRAP;
        end

        default: begin
          state_d = S_FETCH;
        end
      endcase

      // Every new request starts its timeout window from zero.
      if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
        wait_d = '0;
      end
    end
  end

  assign retire_cnt_d = retire_cnt_q + CNT_W'(retire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      run_q        <= 1'b0;
      wait_q       <= '0;
      retire_cnt_q <= '0;
      trap_cause_q <= TRAP_NONE;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      wait_q       <= wait_d;
      retire_cnt_q <= retire_cnt_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign trap_cause = trap_cause_q;
  assign trap       = (state_q == S_TRAP);
  assign dbg_state  = state_q;

endmodule
